// File: rtl/grid_state_manager.sv
// grid_state_manager: sole owner and writer of the 8x13 kitchen object grid; a tick-driven scan ages pots.
// Latency: WRITE, CLEAR and scan steps reach object_grid 1 cycle later; READ data and cmd_err_out 1 cycle after accept.
// Backpressure: cmd_ready_out drops while scanning, clearing or holding a pending tick; extra ticks coalesce.
//
// Ports:
//   pixel_clk_in, rst_n_in       sole clock, asynchronous active-low reset
//   tick_in                      one-cycle game-time pulse, requests one full-grid scan
//   cmd_valid_in / cmd_ready_out command handshake; cmd_op_in 0 WRITE, 1 READ, 2 CLEAR, 3 reserved
//   cmd_x_in, cmd_y_in           cell coordinate (x 0..12, y 0..7); cmd_data_in object code for WRITE
//   rd_valid_out, rd_data_out    READ result, one cycle after accept
//   cmd_err_out                  pulse for a bad coordinate or the reserved op
//   burn_event_out               pulse with scan_done_out if any pot caught fire in that scan
//   scan_done_out                pulse in the IDLE cycle after the last scanned cell
//   object_grid                  registered grid, indexed [y][x]
//
// Build option: define GRID_BURN_EN to let cooked pots age into POT_FIRE. Without it cooked pots
// hold, burn_event_out is tied low and BURN_TICKS has no effect.

module grid_state_manager #(
    parameter int COOK_TICKS = 10,
    parameter int BURN_TICKS = 8
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_n_in,
    input  logic                  tick_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic [1:0]            cmd_op_in,
    input  logic [3:0]            cmd_x_in,
    input  logic [2:0]            cmd_y_in,
    input  logic [3:0]            cmd_data_in,
    output logic                  rd_valid_out,
    output logic [3:0]            rd_data_out,
    output logic                  cmd_err_out,
    output logic                  burn_event_out,
    output logic                  scan_done_out,
    output logic [7:0][12:0][3:0] object_grid
);

    localparam int         NCELL    = 104;
    localparam int         NCOL     = 13;
    localparam logic [6:0] LAST_IDX = 7'd103;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [3:0] OBJ_POT_RAW    = 4'd6;
    localparam logic [3:0] OBJ_POT_COOKED = 4'd7;

`ifdef GRID_BURN_EN
    localparam logic [3:0] OBJ_POT_FIRE = 4'd8;
    localparam int AGE_MAX = (COOK_TICKS > BURN_TICKS) ? COOK_TICKS : BURN_TICKS;
`else
    localparam int AGE_MAX = COOK_TICKS;
`endif
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    localparam logic [AGE_W-1:0] COOK_AGE = AGE_W'(COOK_TICKS);
`ifdef GRID_BURN_EN
    localparam logic [AGE_W-1:0] BURN_AGE = AGE_W'(BURN_TICKS);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Cells are stored flat in linear order y*13+x, which is exactly the
    // packed layout of object_grid[y][x].
    logic [NCELL-1:0][3:0]       cells_q, cells_d;
    logic [NCELL-1:0][AGE_W-1:0] ages_q,  ages_d;

    logic [6:0] idx_q, idx_d;
    logic       tick_pending_q, tick_pending_d;
    logic       rd_valid_q, rd_valid_d;
    logic [3:0] rd_data_q, rd_data_d;
    logic       cmd_err_q, cmd_err_d;
    logic       scan_done_q, scan_done_d;

    logic             cmd_acc;
    logic             coord_ok;
    logic [6:0]       cmd_lin;
    logic             scan_last;
    logic [3:0]       cur_val;
    logic [AGE_W-1:0] cur_age;
    logic [AGE_W-1:0] age_inc;

    assign coord_ok = (cmd_x_in <= 4'd12);
    assign cmd_lin  = 7'(cmd_y_in) * 7'(NCOL) + 7'(cmd_x_in);
    assign cmd_acc  = cmd_valid_in && cmd_ready_out;

    // Cell under the scan/clear pointer. Ages never reach their threshold
    // while stored, so the increment cannot overflow AGE_W bits.
    assign cur_val = cells_q[idx_q];
    assign cur_age = ages_q[idx_q];
    assign age_inc = cur_age + AGE_W'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A pending tick takes priority over commands; the
    // ready equation already blocks commands while one is pending.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_pending_q) begin
                    state_d = ST_SCAN;
                end else if (cmd_acc && (cmd_op_in == OP_CLEAR)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_SCAN: begin
                if (scan_last) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (scan_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_out = (state_q == ST_IDLE) && !tick_pending_q;
        scan_last     = (state_q != ST_IDLE) && (idx_q == LAST_IDX);
    end

    // ------------------------------------------------------------------
    // Burn tracking. The flag is armed fresh at the start of every scan and
    // also folds in a fire on the very last cell so the event is not lost.
    // ------------------------------------------------------------------
`ifdef GRID_BURN_EN
    logic burn_now;
    logic burn_flag_q, burn_flag_d;
    logic burn_event_q, burn_event_d;

    assign burn_now = (state_q == ST_SCAN) && (cur_val == OBJ_POT_COOKED)
                      && (age_inc == BURN_AGE);

    always_comb begin
        burn_flag_d  = burn_flag_q;
        burn_event_d = 1'b0;
        if ((state_q == ST_IDLE) && tick_pending_q) begin
            burn_flag_d = 1'b0;
        end else if (state_q == ST_SCAN) begin
            burn_flag_d = burn_flag_q | burn_now;
            if (scan_last) burn_event_d = burn_flag_q | burn_now;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            burn_flag_q  <= 1'b0;
            burn_event_q <= 1'b0;
        end else begin
            burn_flag_q  <= burn_flag_d;
            burn_event_q <= burn_event_d;
        end
    end

    assign burn_event_out = burn_event_q;
`else
    // BURN_TICKS only matters for the burn build; keep it referenced.
    logic unused_burn_cfg;
    assign unused_burn_cfg = (BURN_TICKS != 0);
    assign burn_event_out  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath next state: command execution, clear sweep and scan aging.
    // ------------------------------------------------------------------
    always_comb begin
        cells_d        = cells_q;
        ages_d         = ages_q;
        idx_d          = idx_q;
        tick_pending_d = tick_pending_q;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        cmd_err_d      = 1'b0;
        scan_done_d    = 1'b0;

        // Ticks arriving while one is already pending are absorbed.
        if (tick_in) tick_pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                idx_d = 7'd0;
                if (tick_pending_q) begin
                    tick_pending_d = 1'b0;
                end else if (cmd_acc) begin
                    case (cmd_op_in)
                        OP_WRITE: begin
                            if (coord_ok) begin
                                cells_d[cmd_lin] = cmd_data_in;
                                ages_d[cmd_lin]  = '0;
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        OP_READ: begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = coord_ok ? cells_q[cmd_lin] : 4'd0;
                            cmd_err_d  = !coord_ok;
                        end
                        OP_CLEAR: begin
                            // Sweep starts from index 0 next cycle.
                        end
                        OP_RSVD: begin
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_CLEAR: begin
                cells_d[idx_q] = 4'd0;
                ages_d[idx_q]  = '0;
                idx_d          = scan_last ? 7'd0 : idx_q + 7'd1;
            end

            ST_SCAN: begin
                case (cur_val)
                    OBJ_POT_RAW: begin
                        if (age_inc == COOK_AGE) begin
                            cells_d[idx_q] = OBJ_POT_COOKED;
                            ages_d[idx_q]  = '0;
                        end else begin
                            ages_d[idx_q] = age_inc;
                        end
                    end
                    OBJ_POT_COOKED: begin
`ifdef GRID_BURN_EN
                        if (burn_now) begin
                            cells_d[idx_q] = OBJ_POT_FIRE;
                            ages_d[idx_q]  = '0;
                        end else begin
                            ages_d[idx_q] = age_inc;
                        end
`else
                        ages_d[idx_q] = '0;
`endif
                    end
                    default: ages_d[idx_q] = '0;
                endcase
                idx_d       = scan_last ? 7'd0 : idx_q + 7'd1;
                scan_done_d = scan_last;
            end

            default: idx_d = 7'd0;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cells_q        <= '0;
            ages_q         <= '0;
            idx_q          <= 7'd0;
            tick_pending_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= 4'd0;
            cmd_err_q      <= 1'b0;
            scan_done_q    <= 1'b0;
        end else begin
            cells_q        <= cells_d;
            ages_q         <= ages_d;
            idx_q          <= idx_d;
            tick_pending_q <= tick_pending_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            cmd_err_q      <= cmd_err_d;
            scan_done_q    <= scan_done_d;
        end
    end

    assign object_grid   = cells_q;
    assign rd_valid_out  = rd_valid_q;
    assign rd_data_out   = rd_data_q;
    assign cmd_err_out   = cmd_err_q;
    assign scan_done_out = scan_done_q;

endmodule

// File: tb/tb_grid_state_manager.sv
// Bench for grid_state_manager: directed scenarios then randomized commands/ticks against a cell-level model.
// Latency: each command is checked one cycle after accept; each scan is checked at its scan_done pulse.
// Backpressure: every wait on cmd_ready_out or scan_done_out is cycle-bounded.

module tb_grid_state_manager;

    localparam int COOK = 3;
    localparam int BURN = 2;
    localparam int NC   = 104;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  tick = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic [1:0]            cmd_op = 2'd0;
    logic [3:0]            cmd_x = 4'd0;
    logic [2:0]            cmd_y = 3'd0;
    logic [3:0]            cmd_data = 4'd0;
    logic                  cmd_ready;
    logic                  rd_valid;
    logic [3:0]            rd_data;
    logic                  cmd_err;
    logic                  burn_event;
    logic                  scan_done;
    logic [7:0][12:0][3:0] grid;

    int checks = 0;
    int errors = 0;

    // Reference model: object code and age per cell, linear index y*13+x.
    int mval[NC];
    int mage[NC];

    always #5 clk = ~clk;

    grid_state_manager #(
        .COOK_TICKS(COOK),
        .BURN_TICKS(BURN)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .tick_in       (tick),
        .cmd_valid_in  (cmd_valid),
        .cmd_ready_out (cmd_ready),
        .cmd_op_in     (cmd_op),
        .cmd_x_in      (cmd_x),
        .cmd_y_in      (cmd_y),
        .cmd_data_in   (cmd_data),
        .rd_valid_out  (rd_valid),
        .rd_data_out   (rd_data),
        .cmd_err_out   (cmd_err),
        .burn_event_out(burn_event),
        .scan_done_out (scan_done),
        .object_grid   (grid)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [415:0] exp_grid();
        logic [7:0][12:0][3:0] g;
        for (int i = 0; i < NC; i++) g[i / 13][i % 13] = 4'(mval[i]);
        return g;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) begin
            mval[i] = 0;
            mage[i] = 0;
        end
    endfunction

    // One full scan of the grid; returns 1 if any pot caught fire.
    function automatic bit model_scan();
        bit burned;
        burned = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (mval[i] == 6) begin
                mage[i]++;
                if (mage[i] == COOK) begin
                    mval[i] = 7;
                    mage[i] = 0;
                end
            end else if (mval[i] == 7) begin
`ifdef GRID_BURN_EN
                mage[i]++;
                if (mage[i] == BURN) begin
                    mval[i] = 8;
                    mage[i] = 0;
                    burned  = 1'b1;
                end
`else
                mage[i] = 0;
`endif
            end else begin
                mage[i] = 0;
            end
        end
        return burned;
    endfunction

    // Called at the sample point after the edge that latched the tick.
    task automatic wait_scan(input string tag, output bit burn_seen);
        int n;
        bit b;
        n = 0;
        while (!scan_done && n < 300) begin
            cycle();
            n++;
        end
        chk({tag, " scan length"}, n, 105);
        burn_seen = burn_event;
        b = model_scan();
        chk({tag, " burn"}, burn_event, b);
        chk({tag, " grid"}, grid, exp_grid());
        chk({tag, " ready after scan"}, cmd_ready, 1'b1);
    endtask

    task automatic do_tick(input string tag, output bit burn_seen);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        wait_scan(tag, burn_seen);
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input int x, input int y,
                          input int d, input bit tk);
        int n;
        int lin;
        bit ok;
        int exp_rd;
        n = 0;
        while (!cmd_ready && n < 500) begin
            cycle();
            n++;
        end
        chk({tag, " ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_y     = 3'(y);
        cmd_data  = 4'(d);
        tick      = tk;
        cycle();
        cmd_valid = 1'b0;
        tick      = 1'b0;
        ok  = (x <= 12);
        lin = y * 13 + x;
        exp_rd = (op == 2'd1 && ok) ? mval[lin] : 0;
        chk({tag, " err"}, cmd_err, (op == 2'd3) || ((op <= 2'd1) && !ok));
        chk({tag, " rd_valid"}, rd_valid, (op == 2'd1));
        if (op == 2'd1) chk({tag, " rd_data"}, rd_data, exp_rd);
        if (op == 2'd0 && ok) begin
            mval[lin] = d;
            mage[lin] = 0;
        end
        if (op == 2'd2) begin
            model_clear();
            n = 0;
            while (!cmd_ready && n < 300) begin
                cycle();
                n++;
            end
            chk({tag, " clear length"}, n, 104);
        end
        chk({tag, " grid"}, grid, exp_grid());
        if (!tk && op != 2'd2) chk({tag, " ready back-to-back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        bit b;
        int n;
        int sd;
        int lowcnt;
        model_clear();

        // Reset state
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk("reset ready", cmd_ready, 1'b1);
        chk("reset grid", grid, '0);
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset rd_data", rd_data, 4'd0);
        chk("reset err", cmd_err, 1'b0);
        chk("reset scan_done", scan_done, 1'b0);
        chk("reset burn", burn_event, 1'b0);

        // WRITE then READ
        do_cmd("write 4,2", 2'd0, 4, 2, 6, 1'b0);
        chk("grid[2][4]", grid[2][4], 4'd6);
        do_cmd("read 4,2", 2'd1, 4, 2, 0, 1'b0);
        chk("read 4,2 value", rd_data, 4'd6);

        // Bad coordinates and reserved op
        do_cmd("write x=13", 2'd0, 13, 1, 9, 1'b0);
        cycle();
        chk("err single pulse", cmd_err, 1'b0);
        do_cmd("read x=15", 2'd1, 15, 3, 0, 1'b0);
        do_cmd("reserved op", 2'd3, 2, 2, 0, 1'b0);

        // Cook and burn on (0,0)
        do_cmd("clear pre-cook", 2'd2, 0, 0, 0, 1'b0);
        do_cmd("write pot 0,0", 2'd0, 0, 0, 6, 1'b0);
`ifdef GRID_BURN_EN
        for (int s = 1; s <= 5; s++) begin
            do_tick("cook scan", b);
            chk("cook cell 0,0", grid[0][0], (s < 3) ? 4'd6 : (s < 5) ? 4'd7 : 4'd8);
            chk("cook burn pulse", b, (s == 5));
        end
`else
        for (int s = 1; s <= 10; s++) begin
            do_tick("cook scan", b);
            chk("cook cell 0,0", grid[0][0], (s < 3) ? 4'd6 : 4'd7);
            chk("cook burn pulse", b, 1'b0);
        end
`endif

        // Tick coincident with an accepted WRITE
        do_cmd("simul write", 2'd0, 12, 7, 6, 1'b1);
        chk("simul ready low", cmd_ready, 1'b0);
        wait_scan("simul scan1", b);
        chk("simul cell scan1", grid[7][12], 4'd6);
        do_tick("simul scan2", b);
        chk("simul cell scan2", grid[7][12], 4'd6);
        do_tick("simul scan3", b);
        chk("simul cell scan3", grid[7][12], 4'd7);

        // Two ticks during CLEAR collapse to one scan
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cycle();
        cmd_valid = 1'b0;
        model_clear();
        n  = 0;
        sd = 0;
        while (!cmd_ready && n < 400) begin
            tick = (n == 2) || (n == 10);
            cycle();
            tick = 1'b0;
            n++;
            if (scan_done) sd++;
        end
        chk("pileup ready-low cycles", n, 209);
        chk("pileup scan_done count", sd, 1);
        b = model_scan();
        chk("pileup burn", burn_event, b);
        chk("pileup grid", grid, exp_grid());
        sd = 0;
        lowcnt = 0;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (scan_done) sd++;
            if (!cmd_ready) lowcnt++;
        end
        chk("pileup no second scan", sd, 0);
        chk("pileup ready stays high", lowcnt, 0);

        // Randomized commands and ticks
        for (int k = 0; k < 250; k++) begin
            int r;
            int x;
            int y;
            int d;
            int dr;
            bit tk;
            r  = $urandom_range(0, 99);
            x  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
            y  = $urandom_range(0, 7);
            dr = $urandom_range(0, 19);
            d  = (dr < 10) ? 6 : (dr < 13) ? 7 : $urandom_range(0, 10);
            tk = ($urandom_range(0, 9) == 0);
            if (r < 40) begin
                do_cmd("rnd write", 2'd0, x, y, d, tk);
                if (tk) wait_scan("rnd write scan", b);
            end else if (r < 65) begin
                do_cmd("rnd read", 2'd1, x, y, 0, tk);
                if (tk) wait_scan("rnd read scan", b);
            end else if (r < 68) begin
                do_cmd("rnd clear", 2'd2, 0, 0, 0, 1'b0);
            end else if (r < 71) begin
                do_cmd("rnd reserved", 2'd3, x, y, 0, 1'b0);
            end else begin
                do_tick("rnd tick", b);
            end
        end

        // Reset in the middle of a scan
        do_cmd("pre-reset write", 2'd0, 5, 5, 7, 1'b0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        repeat (51) cycle();
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid-scan reset grid", grid, '0);
        sd = 0;
        n  = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (scan_done) sd++;
            if (burn_event) n++;
        end
        rst_n = 1'b1;
        cycle();
        chk("post-reset ready", cmd_ready, 1'b1);
        chk("post-reset grid", grid, exp_grid());
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (scan_done) sd++;
            if (burn_event) n++;
        end
        chk("mid-scan reset no scan_done", sd, 0);
        chk("mid-scan reset no burn", n, 0);
        do_cmd("post-reset read", 2'd1, 5, 5, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
